// File: rtl/edp_muldiv_seq_if.sv
// Handshake/operand bundle between the EBOX control side and the mul/div sequencer.
// Bits are numbered [0:WIDTH-1] with bit 0 the MSB/sign.
interface edp_muldiv_seq_if #(
    parameter int unsigned WIDTH = 36
);
    logic             start;
    logic             opDiv;
    logic             signedOp;
    logic [0:WIDTH-1] a;
    logic [0:WIDTH-1] bHi;
    logic [0:WIDTH-1] bLo;
    logic             busy;
    logic             done;
    logic [0:WIDTH-1] resultHi;
    logic [0:WIDTH-1] resultLo;
    logic             noDivide;

    modport master (
        output start, opDiv, signedOp, a, bHi, bLo,
        input  busy, done, resultHi, resultLo, noDivide
    );

    modport slave (
        input  start, opDiv, signedOp, a, bHi, bLo,
        output busy, done, resultHi, resultLo, noDivide
    );
endinterface

// File: rtl/edp_muldiv_seq.sv
// Iterative multiply / divide sequencer for the EBOX data path.
// Works on operand magnitudes (shift-add multiply, restoring shift-subtract divide),
// retiring BITS_PER_CLK bits per ITER cycle, then applies result signs in FIXUP.
module edp_muldiv_seq #(
    parameter int unsigned WIDTH        = 36,
    parameter int unsigned BITS_PER_CLK = 1
) (
    input logic             eboxClk,
    input logic             reset,
    edp_muldiv_seq_if.slave bus
);
    localparam int unsigned Steps = WIDTH / BITS_PER_CLK;
    localparam int unsigned CntW  = $clog2(Steps + 1);
    localparam int unsigned W2    = 2 * WIDTH;

    typedef enum logic [2:0] {StIdle, StSetup, StIter, StFixup, StDone} state_e;

    state_e            state_q, state_d;
    logic              div_q, sgn_q;
    logic [WIDTH-1:0]  a_q, bhi_q, blo_q;
    logic [WIDTH-1:0]  opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              qneg_q, qneg_d, rneg_q, rneg_d, nodiv_pend_q, nodiv_pend_d;
    logic [WIDTH-1:0]  res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic              nodiv_q, nodiv_d;

    logic              a_neg, b_neg, setup_nodiv;
    logic [WIDTH-1:0]  a_mag, mlr_mag;
    logic [W2-1:0]     dvd, dvd_mag;
    logic [W2:0]       q_lim;
    logic [WIDTH-1:0]  it_hi, it_lo;
    logic [WIDTH:0]    it_t;

    // Operand magnitudes, signs and the quotient-overflow check evaluated in SETUP.
    always_comb begin
        a_neg   = sgn_q & a_q[WIDTH-1];
        b_neg   = sgn_q & (div_q ? bhi_q[WIDTH-1] : blo_q[WIDTH-1]);
        a_mag   = a_neg ? (~a_q + WIDTH'(1)) : a_q;
        mlr_mag = b_neg ? (~blo_q + WIDTH'(1)) : blo_q;
        dvd     = {bhi_q, blo_q};
        dvd_mag = b_neg ? (~dvd + W2'(1)) : dvd;
        // |dividend| must stay below |divisor| * (largest quotient magnitude + 1).
        if (!sgn_q) begin
            q_lim = {1'b0, a_mag, {WIDTH{1'b0}}};
        end else if (a_neg ^ b_neg) begin
            q_lim = {2'b00, a_mag, {(WIDTH-1){1'b0}}} + {{(WIDTH+1){1'b0}}, a_mag};
        end else begin
            q_lim = {2'b00, a_mag, {(WIDTH-1){1'b0}}};
        end
        setup_nodiv = div_q & ((a_mag == '0) | ({1'b0, dvd_mag} >= q_lim));
    end

    // One ITER cycle: BITS_PER_CLK unrolled radix-2 steps on {hi, lo}.
    always_comb begin
        it_hi = hi_q;
        it_lo = lo_q;
        it_t  = '0;
        for (int i = 0; i < int'(BITS_PER_CLK); i++) begin
            if (div_q) begin
                it_t = {it_hi, it_lo[WIDTH-1]};
                if (it_t >= {1'b0, opnd_q}) begin
                    it_t  = it_t - {1'b0, opnd_q};
                    it_lo = {it_lo[WIDTH-2:0], 1'b1};
                end else begin
                    it_lo = {it_lo[WIDTH-2:0], 1'b0};
                end
                it_hi = it_t[WIDTH-1:0];
            end else begin
                it_t  = {1'b0, it_hi} + (it_lo[0] ? {1'b0, opnd_q} : '0);
                it_lo = {it_t[0], it_lo[WIDTH-1:1]};
                it_hi = it_t[WIDTH:1];
            end
        end
    end

    // Next state and datapath updates.
    always_comb begin
        state_d      = state_q;
        opnd_d       = opnd_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        cnt_d        = cnt_q;
        qneg_d       = qneg_q;
        rneg_d       = rneg_q;
        nodiv_pend_d = nodiv_pend_q;
        res_hi_d     = res_hi_q;
        res_lo_d     = res_lo_q;
        nodiv_d      = nodiv_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) state_d = StSetup;
            end
            StSetup: begin
                opnd_d       = a_mag;
                qneg_d       = a_neg ^ b_neg;
                rneg_d       = b_neg;
                nodiv_pend_d = setup_nodiv;
                cnt_d        = CntW'(Steps);
                if (div_q) begin
                    hi_d = dvd_mag[W2-1:WIDTH];
                    lo_d = dvd_mag[WIDTH-1:0];
                end else begin
                    hi_d = '0;
                    lo_d = mlr_mag;
                end
                // Overflowed divides skip ITER; FIXUP publishes the raw dividend.
                state_d = setup_nodiv ? StFixup : StIter;
            end
            StIter: begin
                hi_d  = it_hi;
                lo_d  = it_lo;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) state_d = StFixup;
            end
            StFixup: begin
                if (nodiv_pend_q) begin
                    res_hi_d = bhi_q;
                    res_lo_d = blo_q;
                    nodiv_d  = 1'b1;
                end else if (div_q) begin
                    res_hi_d = rneg_q ? (~hi_q + WIDTH'(1)) : hi_q;
                    res_lo_d = qneg_q ? (~lo_q + WIDTH'(1)) : lo_q;
                    nodiv_d  = 1'b0;
                end else begin
                    {res_hi_d, res_lo_d} = qneg_q ? (~{hi_q, lo_q} + W2'(1)) : {hi_q, lo_q};
                    nodiv_d  = 1'b0;
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; operands are captured on the edge that accepts start.
    always_ff @(posedge eboxClk) begin
        if (reset) begin
            state_q      <= StIdle;
            div_q        <= 1'b0;
            sgn_q        <= 1'b0;
            a_q          <= '0;
            bhi_q        <= '0;
            blo_q        <= '0;
            opnd_q       <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            cnt_q        <= '0;
            qneg_q       <= 1'b0;
            rneg_q       <= 1'b0;
            nodiv_pend_q <= 1'b0;
            res_hi_q     <= '0;
            res_lo_q     <= '0;
            nodiv_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            opnd_q       <= opnd_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            cnt_q        <= cnt_d;
            qneg_q       <= qneg_d;
            rneg_q       <= rneg_d;
            nodiv_pend_q <= nodiv_pend_d;
            res_hi_q     <= res_hi_d;
            res_lo_q     <= res_lo_d;
            nodiv_q      <= nodiv_d;
            if (state_q == StIdle && bus.start) begin
                div_q <= bus.opDiv;
                sgn_q <= bus.signedOp;
                a_q   <= bus.a;
                bhi_q <= bus.bHi;
                blo_q <= bus.bLo;
            end
        end
    end

    assign bus.busy     = (state_q == StSetup) || (state_q == StIter) || (state_q == StFixup);
    assign bus.done     = (state_q == StDone);
    assign bus.resultHi = res_hi_q;
    assign bus.resultLo = res_lo_q;
    assign bus.noDivide = nodiv_q;
endmodule

// File: tb/tb_edp_muldiv_seq.sv
// Directed bench for edp_muldiv_seq: a B=1 and a B=2 instance run the same vectors side by side.
module tb_edp_muldiv_seq;
    localparam int W = 36;

    typedef struct {
        logic         div;
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] bhi;
        logic [W-1:0] blo;
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
        logic         end_;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vecs[12];

    always #5 clk = ~clk;

    edp_muldiv_seq_if #(.WIDTH(W)) bus1 ();
    edp_muldiv_seq_if #(.WIDTH(W)) bus2 ();

    edp_muldiv_seq #(.WIDTH(W), .BITS_PER_CLK(1)) u_b1 (.eboxClk(clk), .reset(rst), .bus(bus1));
    edp_muldiv_seq #(.WIDTH(W), .BITS_PER_CLK(2)) u_b2 (.eboxClk(clk), .reset(rst), .bus(bus2));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic st);
        bus1.opDiv = v.div; bus1.signedOp = v.sgn; bus1.a = v.a; bus1.bHi = v.bhi; bus1.bLo = v.blo;
        bus2.opDiv = v.div; bus2.signedOp = v.sgn; bus2.a = v.a; bus2.bHi = v.bhi; bus2.bLo = v.blo;
        bus1.start = st;
        bus2.start = st;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".b1.busy"}, 64'(bus1.busy), 64'(0));
        chk({tag, ".b1.done"}, 64'(bus1.done), 64'(0));
        chk({tag, ".b1.hi"}, 64'(bus1.resultHi), 64'(0));
        chk({tag, ".b1.lo"}, 64'(bus1.resultLo), 64'(0));
        chk({tag, ".b1.nd"}, 64'(bus1.noDivide), 64'(0));
        chk({tag, ".b2.busy"}, 64'(bus2.busy), 64'(0));
        chk({tag, ".b2.done"}, 64'(bus2.done), 64'(0));
        chk({tag, ".b2.hi"}, 64'(bus2.resultHi), 64'(0));
        chk({tag, ".b2.lo"}, 64'(bus2.resultLo), 64'(0));
        chk({tag, ".b2.nd"}, 64'(bus2.noDivide), 64'(0));
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int           lat1, lat2, dc1, dc2, exp1, exp2;
        logic [W-1:0] h1, l1, h2, l2;
        logic         n1, n2, bz1, bz2;
        vec_t         junk;
        lat1 = -1; lat2 = -1; dc1 = 0; dc2 = 0;
        h1 = 'x; l1 = 'x; h2 = 'x; l2 = 'x; n1 = 1'bx; n2 = 1'bx; bz1 = 1'bx; bz2 = 1'bx;
        @(negedge clk);
        drive(v, 1'b1);
        @(posedge clk);
        #1;
        // Operands must have been captured; scramble them from here on.
        junk = v;
        junk.a = ~v.a; junk.bhi = ~v.bhi; junk.blo = ~v.blo;
        junk.div = ~v.div; junk.sgn = ~v.sgn;
        drive(junk, 1'b0);
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (bus1.done) begin
                dc1++;
                if (lat1 < 0) begin
                    lat1 = k; h1 = bus1.resultHi; l1 = bus1.resultLo;
                    n1 = bus1.noDivide; bz1 = bus1.busy;
                end
            end
            if (bus2.done) begin
                dc2++;
                if (lat2 < 0) begin
                    lat2 = k; h2 = bus2.resultHi; l2 = bus2.resultLo;
                    n2 = bus2.noDivide; bz2 = bus2.busy;
                end
            end
        end
        exp1 = v.end_ ? 2 : 38;
        exp2 = v.end_ ? 2 : 20;
        chk($sformatf("v%0d.b1.lat", idx), 64'(lat1), 64'(exp1));
        chk($sformatf("v%0d.b1.hi", idx), 64'(h1), 64'(v.ehi));
        chk($sformatf("v%0d.b1.lo", idx), 64'(l1), 64'(v.elo));
        chk($sformatf("v%0d.b1.nd", idx), 64'(n1), 64'(v.end_));
        chk($sformatf("v%0d.b1.busy", idx), 64'(bz1), 64'(0));
        chk($sformatf("v%0d.b1.ndone", idx), 64'(dc1), 64'(1));
        chk($sformatf("v%0d.b2.lat", idx), 64'(lat2), 64'(exp2));
        chk($sformatf("v%0d.b2.hi", idx), 64'(h2), 64'(v.ehi));
        chk($sformatf("v%0d.b2.lo", idx), 64'(l2), 64'(v.elo));
        chk($sformatf("v%0d.b2.nd", idx), 64'(n2), 64'(v.end_));
        chk($sformatf("v%0d.b2.busy", idx), 64'(bz2), 64'(0));
        chk($sformatf("v%0d.b2.ndone", idx), 64'(dc2), 64'(1));
        // Results are held after completion.
        chk($sformatf("v%0d.b1.hold", idx), 64'(bus1.resultLo), 64'(v.elo));
        chk($sformatf("v%0d.b2.hold", idx), 64'(bus2.resultHi), 64'(v.ehi));
    endtask

    initial begin
        int   dc1, dc2, drop1, drop2;
        logic [W-1:0] h1, l1, h2, l2;

        //          div   sgn   a             bHi           bLo           expHi         expLo         nd
        vecs[0]  = '{1'b0, 1'b0, 36'd3,        36'd0,        36'd5,        36'd0,        36'd15,       1'b0};
        vecs[1]  = '{1'b0, 1'b1, 36'hFFFFFFFF9, 36'd0,       36'd3,        36'hFFFFFFFFF, 36'hFFFFFFFEB, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 36'h800000000, 36'd0,       36'h800000000, 36'h400000000, 36'd0,      1'b0};
        vecs[3]  = '{1'b0, 1'b0, 36'hFFFFFFFFF, 36'd0,       36'hFFFFFFFFF, 36'hFFFFFFFFE, 36'd1,      1'b0};
        vecs[4]  = '{1'b1, 1'b1, 36'd7,        36'd0,        36'd100,      36'd2,        36'd14,       1'b0};
        vecs[5]  = '{1'b1, 1'b1, 36'd7,        36'hFFFFFFFFF, 36'hFFFFFFF9C, 36'hFFFFFFFFE, 36'hFFFFFFFF2, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 36'd0,        36'h1,        36'h2,        36'h1,        36'h2,        1'b1};
        vecs[7]  = '{1'b1, 1'b0, 36'd7,        36'd7,        36'd0,        36'd7,        36'd0,        1'b1};
        vecs[8]  = '{1'b1, 1'b0, 36'd7,        36'd6,        36'd0,        36'd6,        36'hDB6DB6DB6, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 36'hFFFFFFFFF, 36'd0,       36'h800000000, 36'd0,       36'h800000000, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 36'd1,        36'd0,        36'h800000000, 36'd0,       36'h800000000, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 36'hFFFFFFFF9, 36'hFFFFFFFFF, 36'hFFFFFFF9C, 36'hFFFFFFFFE, 36'hE,   1'b0};

        rst = 1'b1;
        drive(vecs[0], 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Reset during ITER cycle 10 aborts and clears everything.
        @(negedge clk);
        drive(vecs[1], 1'b1);
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        bus2.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort.b1.busy_pre", 64'(bus1.busy), 64'(1));
        chk("abort.b2.busy_pre", 64'(bus2.busy), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle("abort");
        rst = 1'b0;
        dc1 = 0; dc2 = 0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            #1;
            if (bus1.done) dc1++;
            if (bus2.done) dc2++;
        end
        chk("abort.b1.ndone", 64'(dc1), 64'(0));
        chk("abort.b2.ndone", 64'(dc2), 64'(0));

        // start held high through busy and DONE: exactly one operation each.
        @(negedge clk);
        drive(vecs[0], 1'b1);
        dc1 = 0; dc2 = 0; drop1 = -1; drop2 = -1;
        h1 = 'x; l1 = 'x; h2 = 'x; l2 = 'x;
        for (int k = 0; k < 90; k++) begin
            @(posedge clk);
            #1;
            if (k == drop1) bus1.start = 1'b0;
            if (k == drop2) bus2.start = 1'b0;
            if (bus1.done) begin
                dc1++;
                if (drop1 < 0) begin drop1 = k + 1; h1 = bus1.resultHi; l1 = bus1.resultLo; end
            end
            if (bus2.done) begin
                dc2++;
                if (drop2 < 0) begin drop2 = k + 1; h2 = bus2.resultHi; l2 = bus2.resultLo; end
            end
        end
        bus1.start = 1'b0;
        bus2.start = 1'b0;
        chk("hold.b1.ndone", 64'(dc1), 64'(1));
        chk("hold.b2.ndone", 64'(dc2), 64'(1));
        chk("hold.b1.lat", 64'(drop1 - 1), 64'(38));
        chk("hold.b2.lat", 64'(drop2 - 1), 64'(20));
        chk("hold.b1.hi", 64'(h1), 64'(0));
        chk("hold.b1.lo", 64'(l1), 64'(15));
        chk("hold.b2.hi", 64'(h2), 64'(0));
        chk("hold.b2.lo", 64'(l2), 64'(15));
        chk("hold.b1.busy", 64'(bus1.busy), 64'(0));
        chk("hold.b2.busy", 64'(bus2.busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
